// File: rtl/isqrt_seq_pkg.sv
// -----------------------------------------------------------------------------
// isqrt_seq_pkg
//   Shared types and constants for the sequential integer square root unit.
//   - isqrt_state_t   : controller states (idle / iterating / result strobe)
//   - ISQRT_X_W       : default operand width
//   - ISQRT_MAX_W     : widest operand the helper function can describe
//   - isqrt_init_bit(): starting "bit" mask, the highest even power of two
//                       that fits in an operand of the given width
// -----------------------------------------------------------------------------
package isqrt_seq_pkg;

  localparam int ISQRT_X_W   = 32;
  localparam int ISQRT_MAX_W = 64;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } isqrt_state_t;

  // The restoring algorithm starts testing at 4^(x_w/2 - 1) = 1 << (x_w-2).
  // Callers truncate the result to their own operand width.
  function automatic logic [ISQRT_MAX_W-1:0] isqrt_init_bit(input int unsigned x_w);
    return ISQRT_MAX_W'(1) << (x_w - 2);
  endfunction

endpackage

// File: rtl/isqrt_step.sv
// -----------------------------------------------------------------------------
// isqrt_step
//   One iteration of the restoring digit-by-digit square root. Purely
//   combinational so it can be reused unrolled or iterated.
//
//   Ports
//     i_op        : remaining radicand
//     i_root      : partial root (pre-scaled, see top)
//     i_bit       : current even power-of-two test mask
//     o_op_next   : radicand after this step
//     o_root_next : partial root after this step
// -----------------------------------------------------------------------------
module isqrt_step #(
  parameter int X_W = 32
) (
  input  logic [X_W-1:0] i_op,
  input  logic [X_W-1:0] i_root,
  input  logic [X_W-1:0] i_bit,
  output logic [X_W-1:0] o_op_next,
  output logic [X_W-1:0] o_root_next
);

  logic [X_W-1:0] w_trial;
  logic           w_fits;

  // root+bit cannot overflow: root's set bits always sit above bit's position
  // and their sum stays below 2^X_W for every reachable state.
  assign w_trial = i_root + i_bit;
  assign w_fits  = (i_op >= w_trial);

  // NOTE: every output is assigned a default before the branch so that no
  // path leaves a value unassigned, which would otherwise infer a latch.
  always_comb begin
    o_op_next   = i_op;
    o_root_next = i_root >> 1;
    if (w_fits) begin
      o_op_next   = i_op - w_trial;
      o_root_next = (i_root >> 1) + i_bit;
    end
  end

endmodule

// File: rtl/isqrt_seq.sv
// -----------------------------------------------------------------------------
// isqrt_seq
//   Sequential unsigned integer square root: y = floor(sqrt(x)).
//   One result bit per cycle through a single isqrt_step instance.
//   Latency: operand accepted in cycle N -> y_vld in cycle N+Y_W+1.
//   An operand may be chained in the y_vld cycle for back-to-back throughput.
//
//   Ports
//     clk    : clock, rising edge
//     rst_n  : asynchronous active-low reset
//     x_vld  : operand strobe (accepted in IDLE or DONE, ignored in CALC)
//     x      : unsigned operand, sampled when accepted
//     y_vld  : one-cycle result strobe
//     y      : result, held until the next result
//     busy   : high while iterating
// -----------------------------------------------------------------------------
module isqrt_seq
  import isqrt_seq_pkg::*;
#(
  parameter int X_W = ISQRT_X_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             x_vld,
  input  logic [X_W-1:0]   x,
  output logic             y_vld,
  output logic [X_W/2-1:0] y,
  output logic             busy
);

  localparam int Y_W   = X_W / 2;
  localparam int CNT_W = (Y_W > 1) ? $clog2(Y_W) : 1;

  localparam logic [X_W-1:0]   INIT_BIT = X_W'(isqrt_init_bit(X_W));
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(Y_W - 1);

  generate
    if ((X_W % 2) != 0 || X_W < 4 || X_W > ISQRT_MAX_W) begin : g_bad_width
      $error("isqrt_seq: X_W must be even and within 4..ISQRT_MAX_W");
    end
  endgenerate

  isqrt_state_t r_state;
  isqrt_state_t w_state_next;

  logic [X_W-1:0]   r_op;
  logic [X_W-1:0]   r_root;
  logic [X_W-1:0]   r_bit;
  logic [CNT_W-1:0] r_cnt;
  logic [Y_W-1:0]   r_y;

  logic [X_W-1:0]   w_op_next;
  logic [X_W-1:0]   w_root_next;
  logic             w_load;
  logic             w_step;
  logic             w_last;

  isqrt_step #(.X_W(X_W)) u_step (
    .i_op        (r_op),
    .i_root      (r_root),
    .i_bit       (r_bit),
    .o_op_next   (w_op_next),
    .o_root_next (w_root_next)
  );

  // ---------------------------------------------------------------------------
  // Controller
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of block order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    w_step       = 1'b0;
    w_last       = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (x_vld) begin
          w_load       = 1'b1;
          w_state_next = ST_CALC;
        end
      end
      ST_CALC: begin
        // x_vld is deliberately not looked at here.
        w_step = 1'b1;
        if (r_cnt == '0) begin
          w_last       = 1'b1;
          w_state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        // Upstream chains its next operand in the strobe cycle.
        if (x_vld) begin
          w_load       = 1'b1;
          w_state_next = ST_CALC;
        end else begin
          w_state_next = ST_IDLE;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op   <= '0;
      r_root <= '0;
      r_bit  <= '0;
      r_cnt  <= '0;
      r_y    <= '0;
    end else if (w_load) begin
      r_op   <= x;
      r_root <= '0;
      r_bit  <= INIT_BIT;
      r_cnt  <= CNT_INIT;
    end else if (w_step) begin
      r_op   <= w_op_next;
      r_root <= w_root_next;
      r_bit  <= r_bit >> 2;
      if (w_last) begin
        // After the final step the root holds the exact result in its low half.
        r_y <= w_root_next[Y_W-1:0];
      end else begin
        r_cnt <= r_cnt - 1'b1;
      end
    end
  end

  // Both strobes decode the state register only, so there is no
  // combinational path from x_vld.
  assign y_vld = (r_state == ST_DONE);
  assign busy  = (r_state == ST_CALC);
  assign y     = r_y;

endmodule

// File: tb/tb_isqrt_seq.sv
// -----------------------------------------------------------------------------
// tb_isqrt_seq
//   Directed table of operands with hand-computed roots, hand-written
//   sequences for chaining, ignored strobes and mid-operation reset, and a
//   short random sweep against an independent floor(sqrt()) model.
// -----------------------------------------------------------------------------
module tb_isqrt_seq;

  localparam int X_W = 32;
  localparam int Y_W = 16;
  localparam int LAT = Y_W + 1;

  typedef struct {
    logic [X_W-1:0] x;
    logic [Y_W-1:0] y;
  } vec_t;

  logic           clk;
  logic           rst_n;
  logic           x_vld;
  logic [X_W-1:0] x;
  logic           y_vld;
  logic [Y_W-1:0] y;
  logic           busy;

  int n_checks;
  int n_fail;

  isqrt_seq #(.X_W(X_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .x_vld (x_vld),
    .x     (x),
    .y_vld (y_vld),
    .y     (y),
    .busy  (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Independent reference: floating-point estimate, then integer correction.
  function automatic logic [Y_W-1:0] ref_sqrt(input logic [X_W-1:0] v);
    longint vv;
    longint r;
    vv = longint'(v);
    r  = longint'($sqrt(real'(vv)));
    while (r * r > vv) r--;
    while ((r + 1) * (r + 1) <= vv) r++;
    return Y_W'(r);
  endfunction

  // Called at a negedge. Presents one operand, watches a 30-cycle window and
  // checks latency, value, pulse count and busy profile.
  task automatic do_op(input string name, input logic [X_W-1:0] xin, input logic [Y_W-1:0] exp);
    int lat;
    int pulses;
    int busy_err;
    logic [Y_W-1:0] y_seen;
    lat      = -1;
    pulses   = 0;
    busy_err = 0;
    y_seen   = '0;
    x_vld    = 1'b1;
    x        = xin;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (k == 1) begin
        x_vld = 1'b0;
        x     = '0;
      end
      if (y_vld) begin
        pulses++;
        if (lat < 0) begin
          lat    = k;
          y_seen = y;
        end
      end
      if ((k < LAT) != busy) busy_err++;
    end
    check({name, ".latency"}, lat, LAT);
    check({name, ".y"}, y_seen, exp);
    check({name, ".pulses"}, pulses, 1);
    check({name, ".busy"}, busy_err, 0);
  endtask

  vec_t vecs[17];

  initial begin
    int lat2;
    int pulses;
    logic [X_W-1:0] rx;

    n_checks = 0;
    n_fail   = 0;

    vecs[0]  = '{x: 32'd0,          y: 16'd0};
    vecs[1]  = '{x: 32'd1,          y: 16'd1};
    vecs[2]  = '{x: 32'd2,          y: 16'd1};
    vecs[3]  = '{x: 32'd3,          y: 16'd1};
    vecs[4]  = '{x: 32'd4,          y: 16'd2};
    vecs[5]  = '{x: 32'd15,         y: 16'd3};
    vecs[6]  = '{x: 32'd16,         y: 16'd4};
    vecs[7]  = '{x: 32'd24,         y: 16'd4};
    vecs[8]  = '{x: 32'd25,         y: 16'd5};
    vecs[9]  = '{x: 32'd99,         y: 16'd9};
    vecs[10] = '{x: 32'd100,        y: 16'd10};
    vecs[11] = '{x: 32'd1000000,    y: 16'd1000};
    vecs[12] = '{x: 32'h3FFF_FFFF,  y: 16'h7FFF};
    vecs[13] = '{x: 32'h4000_0000,  y: 16'h8000};
    vecs[14] = '{x: 32'hFFFE_0000,  y: 16'hFFFE};
    vecs[15] = '{x: 32'hFFFE_0001,  y: 16'hFFFF};
    vecs[16] = '{x: 32'hFFFF_FFFF,  y: 16'hFFFF};

    // Reset state.
    rst_n = 1'b0;
    x_vld = 1'b0;
    x     = '0;
    repeat (3) @(negedge clk);
    check("reset.y_vld", y_vld, 0);
    check("reset.y", y, 0);
    check("reset.busy", busy, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Directed table.
    foreach (vecs[i]) begin
      do_op($sformatf("vec%0d", i), vecs[i].x, vecs[i].y);
    end

    // Chaining: 16 -> 4, then 4+y = 8 presented in the strobe cycle -> 2.
    x_vld = 1'b1;
    x     = 32'd16;
    for (int k = 1; k < LAT; k++) begin
      @(negedge clk);
      if (k == 1) x_vld = 1'b0;
    end
    @(negedge clk);
    check("chain.first_vld", y_vld, 1);
    check("chain.first_y", y, 4);
    x_vld = 1'b1;
    x     = 32'd4 + 32'(y);
    lat2  = -1;
    for (int k = 1; k <= 25; k++) begin
      @(negedge clk);
      if (k == 1) begin
        x_vld = 1'b0;
        check("chain.no_idle_busy", busy, 1);
      end
      if (y_vld && lat2 < 0) begin
        lat2 = k;
        check("chain.second_y", y, 2);
      end
    end
    check("chain.second_latency", lat2, LAT);

    // x_vld during CALC must be ignored.
    x_vld  = 1'b1;
    x      = 32'd81;
    pulses = 0;
    lat2   = -1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      x_vld = (k == 5);
      x     = (k == 5) ? 32'd100 : 32'd0;
      if (y_vld) begin
        pulses++;
        if (lat2 < 0) begin
          lat2 = k;
          check("ignore.y", y, 9);
        end
      end
    end
    check("ignore.latency", lat2, LAT);
    check("ignore.pulses", pulses, 1);

    // Reset dropped mid-operation: result discarded.
    x_vld  = 1'b1;
    x      = 32'd1000;
    pulses = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == 1) x_vld = 1'b0;
      if (k == 8) begin
        rst_n = 1'b0;
        #1;
        check("midrst.busy", busy, 0);
        check("midrst.y", y, 0);
      end
      if (k == 10) rst_n = 1'b1;
      if (y_vld) pulses++;
    end
    check("midrst.pulses", pulses, 0);
    do_op("after_rst", 32'd49, 16'd7);

    // Random sweep against the reference model.
    for (int i = 0; i < 150; i++) begin
      rx = (i % 2 == 0) ? 32'($urandom) : 32'($urandom_range(0, 5000));
      do_op($sformatf("rand%0d", i), rx, ref_sqrt(rx));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  // Global bound so the run cannot hang.
  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
